// File: rtl/sram_pkg.sv
// Shared types and constants for the ZBT/NoBL SRAM responder: op encoding,
// default bus geometry and the pipeline-stage record.
package sram_pkg;

  localparam int SRAM_ADDR_WIDTH     = 20;
  localparam int SRAM_DATA_WIDTH     = 18;
  localparam int SRAM_MEM_DEPTH_LOG2 = 12;
  localparam int SRAM_PIPE_LATENCY   = 2;

  localparam int SRAM_BYTE_WIDTH  = 9;
  localparam int SRAM_BYTE_LO_LSB = 0;
  localparam int SRAM_BYTE_HI_LSB = 9;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } sram_op_e;

  // addr holds the already-aliased array index
  typedef struct packed {
    sram_op_e                       op;
    logic [SRAM_MEM_DEPTH_LOG2-1:0] addr;
    logic [1:0]                     bw;
  } sram_stage_t;

  localparam sram_stage_t SRAM_STAGE_IDLE = '{op: OP_NOP, addr: '0, bw: 2'b11};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_model_array.sv
// Single-port synchronous backing array with per-byte write enables and a
// registered read port; contents survive reset.
module sram_model_array
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int DEPTH_LOG2 = SRAM_MEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  rd_en,
  input  logic [1:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int HALF = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // rdata only moves on an enabled read, so it holds through stalls
  always_ff @(posedge clk) begin
    if (en) begin
      if (we[0]) mem[addr][HALF-1:0]          <= wdata[HALF-1:0];
      if (we[1]) mem[addr][DATA_WIDTH-1:HALF] <= wdata[DATA_WIDTH-1:HALF];
      if (rd_en) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_zbt_responder.sv
// Device-side ZBT/NoBL SRAM model: command decode, linear burst, two-stage
// pipeline, tristate read driver, saturating counters and sticky error.
//
// burst_op | meaning
// OP_NOP   | no burst open; an advance here is a protocol error
// OP_READ  | read burst open; advance issues the next read beat
// OP_WRITE | write burst open; advance issues the next write beat
module sram_zbt_responder
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int MEM_DEPTH_LOG2 = SRAM_MEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  input  logic [1:0]            sram_bw,
  input  logic                  sram_advload,
  input  logic                  sram_write_enable,
  input  logic                  sram_chip_enable,
  input  logic                  sram_oe,
  input  logic                  sram_clk_enable,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count,
  output logic                  protocol_error
);

  logic                      cmd_active;
  sram_op_e                  burst_op;
  logic [MEM_DEPTH_LOG2-1:0] burst_base;
  logic [1:0]                burst_cnt;
  sram_stage_t               stage1, stage2;
  logic                      rd_phase;

  sram_stage_t               dec;
  logic [MEM_DEPTH_LOG2-1:0] dec_base;
  logic [1:0]                dec_cnt;
  logic [1:0]                beat_low;
  logic                      burst_err;

  logic                      mem_rd;
  logic [1:0]                mem_we;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      unused_addr_hi;

  assign cmd_active     = ~sram_clk_enable;
  assign unused_addr_hi = ^sram_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  always_comb begin
    dec       = SRAM_STAGE_IDLE;
    dec.bw    = sram_bw;
    dec_base  = burst_base;
    dec_cnt   = burst_cnt;
    burst_err = 1'b0;
    beat_low  = burst_base[1:0] + burst_cnt + 2'd1;
    if (sram_chip_enable) begin
      if (!sram_advload) begin
        dec.op   = sram_write_enable ? OP_READ : OP_WRITE;
        dec.addr = sram_addr[MEM_DEPTH_LOG2-1:0];
        dec_base = sram_addr[MEM_DEPTH_LOG2-1:0];
        dec_cnt  = 2'd0;
      end else if (burst_op == OP_NOP) begin
        burst_err = 1'b1;
      end else begin
        dec.op   = burst_op;
        dec_cnt  = burst_cnt + 2'd1;
        dec.addr = {burst_base[MEM_DEPTH_LOG2-1:2], beat_low};
      end
    end
  end

  // a deselect or an illegal advance closes the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_op       <= OP_NOP;
      burst_base     <= '0;
      burst_cnt      <= 2'd0;
      stage1         <= SRAM_STAGE_IDLE;
      stage2         <= SRAM_STAGE_IDLE;
      rd_phase       <= 1'b0;
      read_count     <= 16'd0;
      write_count    <= 16'd0;
      protocol_error <= 1'b0;
    end else begin
      if (cmd_active) begin
        burst_op   <= dec.op;
        burst_base <= dec_base;
        burst_cnt  <= dec_cnt;
        stage1     <= dec;
        stage2     <= stage1;
        rd_phase   <= (stage2.op == OP_READ);
        if (stage2.op == OP_READ)  read_count  <= sat_inc16(read_count);
        if (stage2.op == OP_WRITE) write_count <= sat_inc16(write_count);
      end
      if ((cmd_active && burst_err) || (rd_phase && sram_oe))
        protocol_error <= 1'b1;
    end
  end

  assign mem_rd = (stage2.op == OP_READ);
  assign mem_we = (stage2.op == OP_WRITE) ? ~stage2.bw : 2'b00;

  sram_model_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .en    (cmd_active),
    .rd_en (mem_rd),
    .we    (mem_we),
    .addr  (stage2.addr),
    .wdata (sram_data),
    .rdata (rd_word)
  );

  assign sram_data = (rd_phase && !sram_oe) ? rd_word : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_zbt_responder.sv
// Directed plus randomized bench for sram_zbt_responder against a queue-based
// latency model of the SRAM bus.
module tb_sram_zbt_responder;

  localparam int AW = 20;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] sram_addr = '0;
  logic [1:0]    sram_bw = 2'b11;
  logic          sram_advload = 1'b0;
  logic          sram_write_enable = 1'b1;
  logic          sram_chip_enable = 1'b0;
  logic          sram_oe = 1'b0;
  logic          sram_clk_enable = 1'b0;
  tri0 [DW-1:0]  sram_data;
  logic          tb_drv_en = 1'b0;
  logic [DW-1:0] tb_drv = '0;
  logic [15:0]   read_count, write_count;
  logic          protocol_error;

  assign sram_data = tb_drv_en ? tb_drv : {DW{1'bz}};

  sram_zbt_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sram_addr         (sram_addr),
    .sram_data         (sram_data),
    .sram_bw           (sram_bw),
    .sram_advload      (sram_advload),
    .sram_write_enable (sram_write_enable),
    .sram_chip_enable  (sram_chip_enable),
    .sram_oe           (sram_oe),
    .sram_clk_enable   (sram_clk_enable),
    .read_count        (read_count),
    .write_count       (write_count),
    .protocol_error    (protocol_error)
  );

  // op: 0 = none, 1 = read, 2 = write
  typedef struct {
    int            op;
    int            addr;
    logic [1:0]    bw;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_mem [int];
  int            m_last, m_base, m_cnt, m_rc, m_wc;
  bit            m_err, m_rd_active, m_known;
  logic [DW-1:0] m_val;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t idle;
    idle.op = 0; idle.addr = 0; idle.bw = 2'b11; idle.wd = '0;
    q.delete();
    q.push_back(idle);
    q.push_back(idle);
    m_last = 0; m_base = 0; m_cnt = 0;
    m_rc = 0; m_wc = 0; m_err = 0; m_rd_active = 0; m_known = 0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    tb_drv_en = 1'b0;
    sram_chip_enable = 1'b0; sram_clk_enable = 1'b0; sram_oe = 1'b0;
    #1;
    chk("rst_bus", sram_data, 0);
    chk("rst_read_count", read_count, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_protocol_error", protocol_error, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit ce, input bit adv, input bit wen, input logic [1:0] bw,
                      input int addr, input logic [DW-1:0] wd, input bit stall, input bit oe);
    ent_t e, d;
    logic [DW-1:0] w;
    sram_chip_enable = ce; sram_advload = adv; sram_write_enable = wen;
    sram_bw = bw; sram_addr = addr[AW-1:0]; sram_clk_enable = stall; sram_oe = oe;
    tb_drv_en = (q[0].op == 2);
    tb_drv    = q[0].wd;
    @(posedge clk);
    if (m_rd_active && oe) m_err = 1;
    if (!stall) begin
      e.op = 0; e.addr = 0; e.bw = bw; e.wd = wd;
      if (ce && !adv) begin
        e.op = wen ? 1 : 2;
        m_base = addr; m_cnt = 0;
        e.addr = addr % 4096;
      end else if (ce && adv) begin
        if (m_last == 0) m_err = 1;
        else begin
          e.op = m_last;
          m_cnt = (m_cnt + 1) % 4;
          e.addr = ((m_base / 4) * 4 + (m_base % 4 + m_cnt) % 4) % 4096;
        end
      end
      m_last = e.op;
      d = q.pop_front();
      if (d.op == 2) begin
        if (m_mem.exists(d.addr)) begin
          w = m_mem[d.addr];
          if (!d.bw[0]) w[8:0]  = d.wd[8:0];
          if (!d.bw[1]) w[17:9] = d.wd[17:9];
          m_mem[d.addr] = w;
        end else if (d.bw == 2'b00) m_mem[d.addr] = d.wd;
        if (m_wc < 65535) m_wc++;
      end
      m_rd_active = (d.op == 1);
      if (m_rd_active) begin
        m_known = m_mem.exists(d.addr);
        if (m_known) m_val = m_mem[d.addr];
        if (m_rc < 65535) m_rc++;
      end
      q.push_back(e);
    end
    #1 tb_drv_en = 1'b0;
    @(negedge clk);
    if (!(m_rd_active && !oe)) chk("bus_idle", sram_data, 0);
    else if (m_known) chk("bus_data", sram_data, m_val);
    chk("read_count", read_count, m_rc);
    chk("write_count", write_count, m_wc);
    chk("protocol_error", protocol_error, m_err);
  endtask

  task automatic nop();                      step(0, 0, 1, 2'b11, 0, '0, 0, 0); endtask
  task automatic stl();                      step(0, 0, 1, 2'b11, 0, '0, 1, 0); endtask
  task automatic nop_oe();                   step(0, 0, 1, 2'b11, 0, '0, 0, 1); endtask
  task automatic rd(input int a);            step(1, 0, 1, 2'b11, a, '0, 0, 0); endtask
  task automatic bst(input logic [DW-1:0] d); step(1, 1, 1, 2'b00, 0, d, 0, 0); endtask
  task automatic wr(input int a, input logic [DW-1:0] d, input logic [1:0] bw);
    step(1, 0, 0, bw, a, d, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k, a;
    do_reset();

    // write then read, counters after first pair
    nop(); nop();
    wr(32'h00010, 18'h2AAAA, 2'b00); nop();
    rd(32'h00010); nop(); nop();
    chk("t1_data", sram_data, 18'h2AAAA);
    chk("t1_wc", write_count, 1);
    chk("t1_rc", read_count, 1);

    // read directly behind write to the same word
    wr(32'h00020, 18'h3FFFF, 2'b00); rd(32'h00020); nop(); nop();
    chk("t2_data", sram_data, 18'h3FFFF);
    nop();
    chk("t2_z", sram_data, 0);

    // byte enables
    wr(32'h00030, 18'h00000, 2'b00); wr(32'h00030, 18'h3FFFF, 2'b10);
    rd(32'h00030); nop(); nop();
    chk("t3_lo_byte", sram_data, 18'h001FF);
    wr(32'h00030, 18'h3FFFF, 2'b11); nop();
    rd(32'h00030); nop(); nop();
    chk("t3_no_byte", sram_data, 18'h001FF);

    // linear wrap burst
    wr(4, 18'h11111, 2'b00); wr(5, 18'h22222, 2'b00);
    wr(6, 18'h33333, 2'b00); wr(7, 18'h04444, 2'b00); nop();
    rd(6); bst('0); bst('0);
    chk("t4_beat0", sram_data, 18'h33333);
    bst('0);
    chk("t4_beat1", sram_data, 18'h04444);
    nop();
    chk("t4_beat2", sram_data, 18'h11111);
    nop();
    chk("t4_beat3", sram_data, 18'h22222);

    // stall during a read phase
    rd(32'h00010); rd(32'h00020); nop();
    chk("t5_pre", sram_data, 18'h2AAAA);
    repeat (3) begin
      stl();
      chk("t5_hold", sram_data, 18'h2AAAA);
    end
    nop();
    chk("t5_resume", sram_data, 18'h3FFFF);
    nop();

    // output enable withheld during a read phase
    rd(32'h00010); nop(); nop_oe();
    chk("t6_z", sram_data, 0);
    nop_oe();
    chk("t6_err", protocol_error, 1);

    // reset mid-burst, array contents survive
    rd(4); bst('0); bst('0);
    chk("t7_pre", sram_data, 18'h11111);
    do_reset();
    rd(32'h00010); nop(); nop();
    chk("t7_kept", sram_data, 18'h2AAAA);

    // random traffic over a small aliased window
    for (int i = 0; i < 64; i++) wr(($urandom_range(0, 255) << 12) | i, DW'($urandom), 2'b00);
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 255) << 12) | $urandom_range(0, 63);
      case (k)
        0:       nop();
        1:       stl();
        2, 3:    rd(a);
        4, 5:    if (m_last == 1) rd(a);
                 else wr(a, DW'($urandom), 2'($urandom_range(0, 3)));
        6, 7, 8: step(1, 1, 1, 2'($urandom_range(0, 3)), 0, DW'($urandom), 0, 0);
        default: step(0, 0, 1, 2'b11, 0, '0, 0, ($urandom_range(0, 3) == 0));
      endcase
    end
    nop(); nop(); nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_zbt_responder.md
# sram_zbt_responder

Synthesizable responder for the pipelined ZBT/NoBL SRAM bus, the device end of the bus the SRAM controller drives. It decodes address/control, models the two-stage pipeline (write data two cycles after its command, read data two cycles after its command), and backs it with a smaller on-chip array. It replaces the external chip in simulation and FPGA loopback builds, and reports protocol misuse through sticky status outputs.

## Interface
- ADDR_WIDTH, 20, width of sram_addr.
- DATA_WIDTH, 18, width of sram_data; split into two bytes, low = [8:0], high = [17:9].
- MEM_DEPTH_LOG2, 12, log2 of array words; address is aliased to its low MEM_DEPTH_LOG2 bits.
- clk  in  1  bus clock; the controller's sram_clk connects here.
- rst_n  in  1  asynchronous, active-low reset.
- sram_addr  in  ADDR_WIDTH  command address.
- sram_data  inout  DATA_WIDTH  bidirectional data; driven only during read data phases.
- sram_bw  in  2  active-low byte-write enables, sampled with the command.
- sram_advload  in  1  0 = load new address, 1 = burst advance.
- sram_write_enable  in  1  active-low; 0 = write command.
- sram_chip_enable  in  1  active-high; 0 = deselect (NOP).
- sram_oe  in  1  active-low output enable (asynchronous gate on the driver).
- sram_clk_enable  in  1  active-low; 1 = stall (all pipeline state frozen).
- read_count  out  16  reads completed, saturating.
- write_count  out  16  writes committed, saturating.
- protocol_error  out  1  sticky error flag.

## Operation
- Commands are sampled on the clk rising edge when sram_clk_enable = 0:
  - sram_chip_enable = 0: NOP.
  - advload = 0: new command, READ if write_enable = 1, WRITE if write_enable = 0. The address is captured as the burst base, burst counter = 0.
  - advload = 1: repeat the previous command type. The burst counter increments and addr[1:0] wraps modulo 4 (linear); upper bits are held. A burst following a NOP is a NOP and sets protocol_error.
- The pipeline has two stages, each holding {op, aliased addr, bw}. They shift only when sram_clk_enable = 0.
- WRITE at edge N:
  - sram_data is sampled at edge N+2.
  - Each byte is written where its sram_bw bit = 0; sram_bw = 2'b11 writes nothing but still counts.
- READ at edge N:
  - The array is looked up at edge N+2.
  - The output register drives sram_data from after edge N+2 until edge N+3.
  - The driver is enabled only when stage-2 op = READ and sram_oe = 0; otherwise the bus is Z.
- Coherency is inherent and needs no bypass: a READ at N+1 after a WRITE at N sees the new data, because the commit is at N+2 and the lookup at N+3.
- protocol_error sets when:
  - sram_oe = 1 during a read data phase (that read is still counted);
  - a burst-after-NOP occurs.
  It clears only on reset.
- Counters increment at the commit/lookup edge and saturate at 16'hFFFF.

## Timing
- Read latency is 2 edges from command to data driven. Write data is due exactly 2 edges after the command.
- Back-to-back commands of any mix are accepted every cycle, so there are no turnaround cycles. Read→write bus ownership is the controller's concern.
- Stall: while sram_clk_enable = 1:
  - no stage shifts and no sampling occurs;
  - a read phase in progress keeps driving the same data;
  - counters do not change.
- Reset (asynchronous, mid-operation allowed):
  - pipeline ops become NOP; sram_data goes Z immediately; counters = 0; protocol_error = 0; burst state = NOP.
  - Array contents are not reset. In-flight writes are dropped.
- First command is accepted at the first edge after rst_n deasserts.

## Structure
- Package sram_pkg:
  - op encoding OP_NOP / OP_READ / OP_WRITE;
  - SRAM_PIPE_LATENCY = 2;
  - default address/data widths;
  - byte split constants;
  - pipeline-stage struct {op, addr, bw}.
- Sub-module sram_model_array: a single-port synchronous array with 2-bit byte write enables and a registered read, no reset.
- The top level contains the command decoder, burst counter, two-stage pipeline, tristate driver, counters and error logic.

## Test plan
- WRITE addr 0x00010 with data 0x2AAAA at edge 3; READ 0x00010 at edge 5 -> sram_data = 0x2AAAA after edge 7, write_count = 1, read_count = 1.
- WRITE 0x00020 at edge 1 (data 0x3FFFF), READ 0x00020 at edge 2 -> data 0x3FFFF after edge 4; bus Z after edge 5.
- Byte write: store 0x00000, then write 0x3FFFF with bw = 2'b10 -> readback = 0x001FF; with bw = 2'b11 -> unchanged, write_count still increments.
- Burst READ base 0x00006 then 3× advload = 1 -> lookups at 0x6, 0x7, 0x4, 0x5, with data on consecutive cycles.
- sram_clk_enable = 1 for 3 cycles mid-read -> same word held on the bus, read_count frozen; the sequence resumes when the stall is released.
- sram_oe = 1 during a read phase -> bus Z and protocol_error = 1; assert rst_n = 0 mid-burst -> bus Z at once, counters = 0, protocol_error = 0.
